fpu_dispatch: RTL
=================

Name: fpu_dispatch

Overview:
- Issue/writeback front end for the combinational FPU datapath.
- Owns the 64×32 FP register file and accepts decoded FP instructions over a valid/ready handshake.
- Drives the FPU inputs (ctrl, ds_val, dt_val, dd, imm) from registers.
- After a ctrl-dependent latency, captures the FPU result (reg_addr, dd_val) and writes it back.

Parameters:
- MULTI_LAT, 3: EXEC cycles for ctrl 3/4/5 (fmul/finv/fsqrt, multicycle paths); must be ≥1.
- SHORT_LAT, 1: EXEC cycles for all other ctrl codes; must be ≥1.

Ports:
- clk  in  1  clock
- rstn  in  1  reset; asynchronous, active-low
- in_valid  in  1  instruction offered
- in_ready  out  1  dispatcher can accept
- in_ctrl  in  4  FPU op code (0/15 = nop)
- in_ds  in  6  source register 1 index
- in_dt  in  6  source register 2 index
- in_dd  in  6  destination register index
- in_imm  in  16  immediate (lookup index in [6:0])
- fpu_ctrl  out  4  to FPU ctrl
- fpu_ds_val  out  32  to FPU ds_val
- fpu_dt_val  out  32  to FPU dt_val
- fpu_dd  out  6  to FPU dd
- fpu_imm  out  16  to FPU imm
- fpu_reg_addr  in  6  from FPU reg_addr (0 = no write)
- fpu_dd_val  in  32  from FPU dd_val
- rd_addr  in  6  auxiliary register file read index
- rd_data  out  32  combinational regfile[rd_addr]
- wb_valid  out  1  one-cycle retire pulse
- wb_addr  out  6  retired destination index
- wb_data  out  32  retired value

Behaviour:
- Reset (rstn low, asynchronous):
  - state = IDLE; all regfile entries = 0.
  - fpu_* outputs = 0; wb_valid/wb_addr/wb_data = 0.
  - in_ready = 1 once reset is released.
- FSM, two states:
  - IDLE: in_ready = 1.
    - On in_valid, latch fpu_ctrl = in_ctrl, fpu_dd = in_dd, fpu_imm = in_imm.
    - Latch fpu_ds_val = regfile[in_ds] and fpu_dt_val = regfile[in_dt], read in the same cycle.
    - Load cnt = (in_ctrl ∈ {3,4,5}) ? MULTI_LAT−1 : SHORT_LAT−1; go to EXEC.
  - EXEC: in_ready = 0; fpu_* held stable.
    - If cnt ≠ 0: cnt decrements.
    - If cnt = 0: on that edge, write regfile[fpu_reg_addr] = fpu_dd_val if fpu_reg_addr ≠ 0.
    - On the same edge, register wb_valid = 1, wb_addr = fpu_reg_addr, wb_data = fpu_dd_val; fpu_ctrl returns to 0; go to IDLE.
- wb_valid is high for exactly one cycle, in the first IDLE cycle after completion; otherwise 0. wb_addr/wb_data hold their last values.
- Latency from accept edge to wb_valid: L+1 cycles, where L is the EXEC length. Throughput: one instruction per L+1 cycles.
- Data hazards: none. The write happens before the next accept, so a dependent instruction accepted in the wb_valid cycle reads the new value.
- Register 0:
  - Never written; reads always return 0.
  - Nop (ctrl 0/15) or dd = 0 still retires: wb_valid = 1, wb_addr = 0, no regfile change.
- rd_data: combinational. A read of the entry being written on the current edge returns the old value until after the edge.
- Reset mid-EXEC aborts the operation: no writeback, no wb_valid.
- in_valid while in_ready = 0 is ignored; upstream holds the instruction until accepted.

Optional Feature:
- Macro: FPU_DISPATCH_PERF_EN.
- Defined:
  - Adds output perf_retired (32 bits), reset to 0.
  - Increments on every wb_valid pulse, nops included.
  - Wraps from 0xFFFFFFFF to 0.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
(Bench instantiates fpu_dispatch wired to the FPU; MULTI_LAT=3, SHORT_LAT=1.)
- Reset then release:
  - in_ready = 1, wb_valid = 0, fpu_ctrl = 0.
  - rd_data = 0 for rd_addr 0..63.
- Lookup, ctrl=14 imm=2 dd=5:
  - in_ready low 1 cycle; wb_valid with wb_addr = 5, wb_data = 0x3F800000.
  - rd_addr = 5 then reads 0x3F800000.
- Add with back-to-back dependency:
  - Load f1 = 1.0 (imm 2) and f2 = 2.0 (imm 3), then ctrl=1 ds=1 dt=2 dd=3, each issued in the wb_valid cycle of the previous.
  - Expect wb_data = 0x40400000.
- Multicycle mul, ctrl=3 ds=3 dt=3 dd=4:
  - in_ready low exactly 3 cycles.
  - wb_data = 0x41100000 (9.0); regfile[4] = 0x41100000.
- Discard target, ctrl=1 dd=0, then ctrl=0 dd=7:
  - Both retire with wb_addr = 0; rd_addr 0 and 7 read 0.
- Abort: rstn low during cycle 2 of the fmul EXEC:
  - No wb_valid; all regfile entries 0.
  - in_ready = 1 after release.
  - With FPU_DISPATCH_PERF_EN, perf_retired = 0.

Source files
------------

// File: rtl/fpu_dispatch.sv
// -----------------------------------------------------------------------------
// fpu_dispatch
//
// Issue / writeback front end for the combinational FPU datapath. Owns the
// 64 x 32-bit FP register file, accepts one decoded FP instruction at a time
// over a valid/ready handshake, presents the operands to the FPU from
// registers, waits a ctrl-dependent number of EXEC cycles, then captures the
// FPU result and writes it back.
//
// Parameters
//   MULTI_LAT  EXEC cycles for ctrl 3/4/5 (fmul/finv/fsqrt); must be >= 1
//   SHORT_LAT  EXEC cycles for every other ctrl code;       must be >= 1
//
// Ports
//   clk, rstn                 clock, asynchronous active-low reset
//   in_valid / in_ready       instruction handshake
//   in_ctrl, in_ds, in_dt,    decoded instruction: op code, source indices,
//   in_dd, in_imm             destination index, immediate
//   fpu_ctrl, fpu_ds_val,     registered operands driven to the FPU
//   fpu_dt_val, fpu_dd,
//   fpu_imm
//   fpu_reg_addr, fpu_dd_val  FPU result (reg_addr 0 = no write)
//   rd_addr / rd_data         auxiliary combinational register file read
//   wb_valid, wb_addr,        one-cycle retire pulse with the retired
//   wb_data                   destination and value (addr/data hold)
//
// Optional feature
//   FPU_DISPATCH_PERF_EN      when defined, adds output perf_retired, a
//                             wrapping 32-bit count of retired instructions
//                             (nops included)
// -----------------------------------------------------------------------------
module fpu_dispatch #(
  parameter int unsigned MULTI_LAT = 3,
  parameter int unsigned SHORT_LAT = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_ctrl,
  input  logic [5:0]  in_ds,
  input  logic [5:0]  in_dt,
  input  logic [5:0]  in_dd,
  input  logic [15:0] in_imm,
  output logic [3:0]  fpu_ctrl,
  output logic [31:0] fpu_ds_val,
  output logic [31:0] fpu_dt_val,
  output logic [5:0]  fpu_dd,
  output logic [15:0] fpu_imm,
  input  logic [5:0]  fpu_reg_addr,
  input  logic [31:0] fpu_dd_val,
  input  logic [5:0]  rd_addr,
  output logic [31:0] rd_data,
  output logic        wb_valid,
  output logic [5:0]  wb_addr,
  output logic [31:0] wb_data
`ifdef FPU_DISPATCH_PERF_EN
  ,
  output logic [31:0] perf_retired
`endif
);

  // Counter only has to hold the largest "remaining cycles" value, L-1.
  localparam int unsigned MAX_LAT = (MULTI_LAT > SHORT_LAT) ? MULTI_LAT : SHORT_LAT;
  localparam int unsigned CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  localparam logic [CNT_W-1:0] MULTI_LOAD = CNT_W'(MULTI_LAT - 1);
  localparam logic [CNT_W-1:0] SHORT_LOAD = CNT_W'(SHORT_LAT - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_EXEC = 1'b1
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             done;
  logic             is_multi;

  logic [31:0]      regs [64];

  // ---------------------------------------------------------------------------
  // Handshake / completion qualifiers
  // ---------------------------------------------------------------------------
  assign accept   = (state == S_IDLE) && in_valid;
  assign done     = (state == S_EXEC) && (cnt == '0);
  assign is_multi = (in_ctrl == 4'd3) || (in_ctrl == 4'd4) || (in_ctrl == 4'd5);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is always assigned with <=, so every flop samples
  // the pre-edge value of every other flop regardless of block ordering.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: the default assignment at the top keeps this block free of latches
  // on every path through the case statement.
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE: if (in_valid) state_next = S_EXEC;
      S_EXEC: if (cnt == '0) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    in_ready = 1'b0;
    unique case (state)
      S_IDLE:  in_ready = 1'b1;
      S_EXEC:  in_ready = 1'b0;
      default: in_ready = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // EXEC cycle counter: loaded with L-1 at accept, counts down to 0.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= is_multi ? MULTI_LOAD : SHORT_LOAD;
    end else if ((state == S_EXEC) && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // FPU operand registers. Operands are read from the register file in the
  // accept cycle and held for the whole EXEC phase; only ctrl drops back to
  // nop on completion so the FPU idles between instructions.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fpu_ctrl   <= '0;
      fpu_ds_val <= '0;
      fpu_dt_val <= '0;
      fpu_dd     <= '0;
      fpu_imm    <= '0;
    end else if (accept) begin
      fpu_ctrl   <= in_ctrl;
      fpu_ds_val <= regs[in_ds];
      fpu_dt_val <= regs[in_dt];
      fpu_dd     <= in_dd;
      fpu_imm    <= in_imm;
    end else if (done) begin
      fpu_ctrl   <= '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Register file. Entry 0 is never written, so it stays at its reset value of
  // zero and reads of f0 always return 0.
  // ---------------------------------------------------------------------------
  // NOTE: the array is cleared on reset because architectural state must be
  // zero after reset; this forces flops rather than a RAM macro, which is the
  // intended trade-off for a 64-entry file.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 64; i++) begin
        regs[i] <= '0;
      end
    end else if (done && (fpu_reg_addr != 6'd0)) begin
      regs[fpu_reg_addr] <= fpu_dd_val;
    end
  end

  // Combinational read: a same-edge write is only visible after the edge.
  assign rd_data = regs[rd_addr];

  // ---------------------------------------------------------------------------
  // Writeback / retire. wb_valid pulses in the first IDLE cycle after
  // completion; address and data hold their last retired values.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wb_valid <= 1'b0;
      wb_addr  <= '0;
      wb_data  <= '0;
    end else begin
      wb_valid <= done;
      if (done) begin
        wb_addr <= fpu_reg_addr;
        wb_data <= fpu_dd_val;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Optional retired-instruction counter. It advances on the completion edge,
  // i.e. together with the rising wb_valid, and wraps naturally at 2^32.
  // ---------------------------------------------------------------------------
`ifdef FPU_DISPATCH_PERF_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      perf_retired <= '0;
    end else if (done) begin
      perf_retired <= perf_retired + 32'd1;
    end
  end
`else
  // No performance counter in this build.
`endif

endmodule
